// File: rtl/sync_event_delay_pkg.sv
// Shared types and constants for the event synchronizer / delay block.
// Edge selection codes, FSM state encoding and counter sizing.
package sync_event_delay_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PULSE
    } state_t;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    function automatic int cnt_width(input int dly, input int pw);
        int mx;
        mx = (dly > pw) ? dly : pw;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/sync_event_delay_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Chain clears asynchronously on reset_n low.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sync_event_delay.sv
// Synchronizes an async trigger, detects edges and issues a delayed
// fixed-width pulse; also delays the AND of two levels by the same depth.
module sync_event_delay
    import sync_event_delay_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DELAY_CYCLES = 10,
    parameter int PULSE_CYCLES = 1,
    parameter int EDGE_MODE    = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic trig_in,
    input  logic and_in0,
    input  logic and_in1,
    input  logic clr_overrun,
    output logic pulse_out,
    output logic busy,
    output logic overrun,
    output logic and_dly
);

    localparam int CW = cnt_width(DELAY_CYCLES, PULSE_CYCLES);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] DLY_LOAD  = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0] PLS_LOAD  = CW'(PULSE_CYCLES - 1);

    logic trig_s;
    logic trig_h;
    logic rise;
    logic fall;
    logic evt;
    logic take;

    state_t        state;
    logic [CW-1:0] cnt;

    logic [DELAY_CYCLES-1:0] and_sr;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (trig_in),
        .q       (trig_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_h <= 1'b0;
        end else begin
            trig_h <= trig_s;
        end
    end

    assign rise = trig_s & ~trig_h;
    assign fall = ~trig_s & trig_h;
    assign evt  = (EDGE_MODE == EDGE_RISE) ? rise :
                  (EDGE_MODE == EDGE_FALL) ? fall :
                  (rise | fall);
    assign take = evt & enable;

    // WAIT leaves one count early so the first pulse cycle is exactly
    // DELAY_CYCLES after the event; DELAY_CYCLES==1 skips WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        busy <= 1'b1;
                        if (DELAY_CYCLES == 1) begin
                            state     <= PULSE;
                            cnt       <= PLS_LOAD;
                            pulse_out <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= DLY_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == ONE) begin
                        state     <= PULSE;
                        cnt       <= PLS_LOAD;
                        pulse_out <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        pulse_out <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (take && busy) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            and_sr <= '0;
        end else begin
            and_sr[0] <= and_in0 & and_in1;
            for (int i = 1; i < DELAY_CYCLES; i++) begin
                and_sr[i] <= and_sr[i-1];
            end
        end
    end

    assign and_dly = and_sr[DELAY_CYCLES-1];

endmodule

// File: tb/tb_sync_event_delay.sv
// Directed bench: three instances (rise / fall / both edges) share stimulus.
// Each vector is a 48-cycle input waveform with expected pulse/busy summaries.
module tb_sync_event_delay;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic trig_in;
    logic and_in0;
    logic and_in1;
    logic clr_overrun;

    logic [2:0] pulse;
    logic [2:0] busy;
    logic [2:0] ovr;
    logic [2:0] andd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_event_delay #(
        .SYNC_STAGES(2), .DELAY_CYCLES(10), .PULSE_CYCLES(3), .EDGE_MODE(0)
    ) u_rise (
        .clk(clk), .reset_n(reset_n), .enable(enable), .trig_in(trig_in),
        .and_in0(and_in0), .and_in1(and_in1), .clr_overrun(clr_overrun),
        .pulse_out(pulse[0]), .busy(busy[0]), .overrun(ovr[0]),
        .and_dly(andd[0])
    );

    sync_event_delay #(
        .SYNC_STAGES(2), .DELAY_CYCLES(10), .PULSE_CYCLES(3), .EDGE_MODE(1)
    ) u_fall (
        .clk(clk), .reset_n(reset_n), .enable(enable), .trig_in(trig_in),
        .and_in0(and_in0), .and_in1(and_in1), .clr_overrun(clr_overrun),
        .pulse_out(pulse[1]), .busy(busy[1]), .overrun(ovr[1]),
        .and_dly(andd[1])
    );

    sync_event_delay #(
        .SYNC_STAGES(2), .DELAY_CYCLES(10), .PULSE_CYCLES(3), .EDGE_MODE(2)
    ) u_both (
        .clk(clk), .reset_n(reset_n), .enable(enable), .trig_in(trig_in),
        .and_in0(and_in0), .and_in1(and_in1), .clr_overrun(clr_overrun),
        .pulse_out(pulse[2]), .busy(busy[2]), .overrun(ovr[2]),
        .and_dly(andd[2])
    );

    typedef struct packed {
        logic [7:0] fp;
        logic [7:0] lp;
        logic [7:0] np;
        logic [7:0] nb;
        logic       ov;
    } exp_t;

    typedef struct packed {
        logic [47:0] trig;
        logic [47:0] en;
        logic [47:0] clr;
        logic [47:0] a0;
        logic [47:0] a1;
        logic [47:0] andx;
        exp_t        m0;
        exp_t        m1;
        exp_t        m2;
    } vec_t;

    localparam logic [47:0] ALL = 48'hFFFF_FFFF_FFFF;

    vec_t  vecs  [9];
    string names [9];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input int fp, input int lp, input int np,
                                input int nb, input bit ov);
        exp_t e;
        e.fp = 8'(fp);
        e.lp = 8'(lp);
        e.np = 8'(np);
        e.nb = 8'(nb);
        e.ov = ov;
        return e;
    endfunction

    function automatic vec_t mkv(input logic [47:0] trig, input logic [47:0] en,
                                 input logic [47:0] clr, input logic [47:0] a0,
                                 input logic [47:0] a1, input logic [47:0] andx,
                                 input exp_t m0, input exp_t m1, input exp_t m2);
        vec_t v;
        v.trig = trig;
        v.en   = en;
        v.clr  = clr;
        v.a0   = a0;
        v.a1   = a1;
        v.andx = andx;
        v.m0   = m0;
        v.m1   = m1;
        v.m2   = m2;
        return v;
    endfunction

    function automatic exp_t pick(input vec_t v, input int m);
        case (m)
            0:       return v.m0;
            1:       return v.m1;
            default: return v.m2;
        endcase
    endfunction

    task automatic do_reset();
        reset_n     = 1'b0;
        enable      = 1'b0;
        trig_in     = 1'b0;
        and_in0     = 1'b0;
        and_in1     = 1'b0;
        clr_overrun = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            check($sformatf("reset m%0d outs", m),
                  {60'd0, pulse[m], busy[m], ovr[m], andd[m]}, 64'd0);
        end
        reset_n = 1'b1;
    endtask

    task automatic run_case(input string nm, input vec_t v, input bit rst);
        int          fp [3];
        int          lp [3];
        int          np [3];
        int          nb [3];
        logic [47:0] andw;
        exp_t        e;
        if (rst) do_reset();
        andw = '0;
        for (int m = 0; m < 3; m++) begin
            fp[m] = 0;
            lp[m] = 0;
            np[m] = 0;
            nb[m] = 0;
        end
        for (int j = 0; j < 48; j++) begin
            trig_in     = v.trig[j];
            enable      = v.en[j];
            clr_overrun = v.clr[j];
            and_in0     = v.a0[j];
            and_in1     = v.a1[j];
            @(posedge clk);
            #1;
            for (int m = 0; m < 3; m++) begin
                if (pulse[m]) begin
                    if (np[m] == 0) fp[m] = j;
                    lp[m] = j;
                    np[m]++;
                end
                if (busy[m]) nb[m]++;
            end
            andw[j] = andd[0];
        end
        for (int m = 0; m < 3; m++) begin
            e = pick(v, m);
            check($sformatf("%s m%0d first", nm, m), 64'(fp[m]), 64'(e.fp));
            check($sformatf("%s m%0d last", nm, m), 64'(lp[m]), 64'(e.lp));
            check($sformatf("%s m%0d npulse", nm, m), 64'(np[m]), 64'(e.np));
            check($sformatf("%s m%0d nbusy", nm, m), 64'(nb[m]), 64'(e.nb));
            check($sformatf("%s m%0d overrun", nm, m), 64'(ovr[m]), 64'(e.ov));
        end
        check($sformatf("%s and_dly", nm), 64'(andw), 64'(v.andx));
        check($sformatf("%s and_dly agree", nm),
              {61'd0, andd}, {61'd0, {3{andd[0]}}});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t none;
        exp_t one;
        int   seen;
        none = mk(0, 0, 0, 0, 0);
        one  = mk(13, 15, 3, 12, 0);

        names[0] = "single";
        vecs[0]  = mkv(48'hFFFF_FFFF_FFFC, ALL, 48'h0, 48'h8, 48'h8,
                       48'h1000, one, none, one);
        names[1] = "overrun";
        vecs[1]  = mkv(48'hFFFF_FFFF_FF9C, ALL, 48'h0, 48'h8, 48'h1, 48'h0,
                       mk(13, 15, 3, 12, 1), mk(16, 18, 3, 12, 0),
                       mk(13, 15, 3, 12, 1));
        names[2] = "clr";
        vecs[2]  = mkv(48'hFFFF_FFFF_FF9C, ALL, 48'h10_0000, 48'h0, 48'h0,
                       48'h0, one, mk(16, 18, 3, 12, 0), one);
        names[3] = "clr_vs_set";
        vecs[3]  = mkv(48'hFFFF_FFFF_FF9C, ALL, 48'h200, 48'h0, 48'h0, 48'h0,
                       mk(13, 15, 3, 12, 1), mk(16, 18, 3, 12, 0),
                       mk(13, 15, 3, 12, 1));
        names[4] = "disabled";
        vecs[4]  = mkv(48'hFFFF_FFFF_FFFC, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0,
                       none, none, none);
        names[5] = "en_drop";
        vecs[5]  = mkv(48'hFFFF_FFFF_FFFC, 48'h3F, 48'h0, 48'h0, 48'h0, 48'h0,
                       one, none, one);
        names[6] = "b2b_drop";
        vecs[6]  = mkv(48'hFFFF_FFFF_C0FC, ALL, 48'h0, 48'h0, 48'h0, 48'h0,
                       mk(13, 15, 3, 12, 1), mk(19, 21, 3, 12, 0),
                       mk(13, 15, 3, 12, 1));
        names[7] = "b2b_accept";
        vecs[7]  = mkv(48'hFFFF_FFFF_80FC, ALL, 48'h0, 48'h0, 48'h0, 48'h0,
                       mk(13, 28, 6, 24, 0), mk(19, 21, 3, 12, 0),
                       mk(13, 28, 6, 24, 1));
        names[8] = "both_edges";
        vecs[8]  = mkv(48'h0000_003F_FFFC, ALL, 48'h0, 48'hE0, 48'h3C0,
                       48'h1_8000, one, mk(33, 35, 3, 12, 0),
                       mk(13, 35, 6, 24, 0));

        for (int i = 0; i < 9; i++) begin
            run_case(names[i], vecs[i], 1'b1);
        end

        // async reset in the 4th WAIT cycle with overrun and and_dly set
        do_reset();
        enable  = 1'b1;
        and_in0 = 1'b1;
        and_in1 = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            trig_in = (j == 5) || (j >= 7);
            @(posedge clk);
            #1;
        end
        check("pre-rst busy", 64'(busy[0]), 64'd1);
        check("pre-rst overrun", 64'(ovr[0]), 64'd1);
        check("pre-rst and_dly", 64'(andd[0]), 64'd1);
        check("pre-rst pulse", 64'(pulse[0]), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst outs", {52'd0, pulse, busy, ovr, andd}, 64'd0);
        trig_in = 1'b0;
        and_in0 = 1'b0;
        and_in1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen = 0;
        for (int j = 0; j < 30; j++) begin
            @(posedge clk);
            #1;
            if ((pulse | busy | ovr | andd) != 3'b000) seen++;
        end
        check("post-rst quiet", 64'(seen), 64'd0);
        run_case("rst_then_edge", vecs[0], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
